money_bcd_scan: RTL and testbench
=================================

MONEY_BCD_SCAN -- requirements
Module: money_bcd_scan

Interface
REQ-001 The module SHALL have parameter SCAN_DIV, default 10000, giving the number of clk cycles each digit is held active (legal range 2..65535).
REQ-002 The module SHALL have port clk, input, 1 bit: the single system clock; all state updates on its rising edge.
REQ-003 The module SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-004 The module SHALL have port display_money_binary, input, 8 bits: unsigned money value 0..255 to display.
REQ-005 The module SHALL have port seg_com, output, 8 bits: digit select, active-low one-hot; bit 0 is the rightmost digit.
REQ-006 The module SHALL have port seg_array, output, 8 bits: segments, active-high, bit7..bit0 = a,b,c,d,e,f,g,dp.
REQ-007 The module SHALL have port conv_busy, output, 1 bit: high while a binary-to-BCD conversion is in progress.

Function
REQ-008 Conversion FSM SHALL have states IDLE, LOAD, SHIFT and DONE, with one state per clk cycle except SHIFT.
REQ-009 IDLE -> LOAD SHALL occur when valid_flag=0 or display_money_binary != last_value; otherwise the FSM stays in IDLE.
REQ-010 LOAD SHALL latch display_money_binary into a shift register and into last_value, and clear the 12-bit BCD accumulator.
REQ-011 SHIFT SHALL run exactly 8 cycles (3-bit iteration counter, 0..7). Each cycle: add 3 to every BCD nibble >= 5, then shift {bcd,bin} left by 1.
REQ-012 DONE SHALL copy hundreds/tens/ones nibbles into the display digit registers in a single cycle, set valid_flag=1, and return to IDLE.
REQ-013 Latency: a value change sampled in IDLE at edge t SHALL appear in the digit registers at edge t+10 (1 LOAD + 8 SHIFT + 1 DONE).
REQ-014 Input changes during LOAD/SHIFT/DONE SHALL NOT disturb the conversion in progress; the FSM SHALL detect the mismatch in the next IDLE cycle and reconvert.
REQ-015 The display digit registers SHALL change only in DONE, so partial BCD values are never displayed.
REQ-016 conv_busy SHALL be 1 in LOAD, SHIFT and DONE, and 0 in IDLE.
REQ-017 The scan counter SHALL count 0..SCAN_DIV-1 and wrap to 0.
REQ-018 On each scan-counter wrap, the digit index SHALL advance 0->1->...->7->0.
REQ-019 seg_com SHALL be registered and equal ~(8'b1 << digit_index).
REQ-020 seg_array SHALL be registered and updated in the same cycle as seg_com, so the two are never mismatched.
REQ-021 Digit index 0 SHALL show ones, index 1 tens, and index 2 hundreds.
REQ-022 Digit indices 3..7 SHALL always show blank (seg_array = 8'h00).
REQ-023 Leading-zero blanking: the hundreds digit SHALL be blank when hundreds=0.
REQ-024 Leading-zero blanking: the tens digit SHALL be blank when hundreds=0 and tens=0.
REQ-025 The ones digit SHALL never be blanked.
REQ-026 Segment codes SHALL be: 0=FC, 1=60, 2=DA, 3=F2, 4=66, 5=B6, 6=BE, 7=E4, 8=FE, 9=F6, blank=00 (hex).
REQ-027 The dp segment (bit 0) SHALL always be 0.
REQ-028 Maximum input 255 SHALL display "255" with no overflow; every BCD nibble SHALL stay within 0..9.

Reset
REQ-029 While rst=1, the following SHALL hold: FSM=IDLE, valid_flag=0, last_value=0, BCD and shift registers=0, digit registers=0, scan counter=0, digit_index=0.
REQ-030 While rst=1, outputs SHALL be seg_com=8'hFE, seg_array=8'hFC ("0" on the rightmost digit), and conv_busy=0.
REQ-031 After rst deasserts, the first IDLE cycle SHALL start a conversion regardless of the input value, because valid_flag=0.
REQ-032 rst asserted mid-conversion SHALL abort the conversion immediately (asynchronously) and restore all reset values; no partial result SHALL reach the display.

Verification
REQ-033 Scenario: SCAN_DIV=4, reset, input 0 -> conv_busy high for 10 cycles; seg_com walks FE,FD,FB,...,7F with each value held 4 cycles; seg_array FC on index 0 and 00 elsewhere.
REQ-034 Scenario: input 8'd255 -> after 10 cycles digit 0=B6, digit 1=B6, digit 2=DA, digits 3..7=00.
REQ-035 Scenario: input 8'd7 -> digit 0=E4, digits 1 and 2 blank.
REQ-036 Scenario: input 8'd105 -> digit 0=B6, digit 1=FC (interior zero shown), digit 2=60.
REQ-037 Scenario: input 8'd30 changed to 8'd99 during SHIFT cycle 4 -> "30" is displayed, then conv_busy reasserts within 1 cycle of DONE and "99" (F6,F6) is displayed 10 cycles later; "30"/"99" never mix.
REQ-038 Scenario: rst pulsed during SHIFT while displaying "150" -> outputs return immediately to FE/FC with conv_busy=0; after release, the current input is reconverted and displayed.

Source files
------------

// File: rtl/money_bcd_scan.sv
// Converts an 8-bit money value to BCD (sequential double-dabble) and drives an
// eight-digit multiplexed 7-segment display with leading-zero blanking.
module money_bcd_scan #(
   parameter int unsigned SCAN_DIV = 10000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] display_money_binary,
   output logic [7:0] seg_com,
   output logic [7:0] seg_array,
   output logic       conv_busy
);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] LOAD  = 2'd1;
   localparam logic [1:0] SHIFT = 2'd2;
   localparam logic [1:0] DONE  = 2'd3;

   localparam logic [15:0] SCAN_MAX = 16'(SCAN_DIV - 1);

   logic [1:0]  r_state;
   logic        r_valid;
   logic [7:0]  r_last;
   logic [7:0]  r_bin;
   logic [11:0] r_bcd;
   logic [2:0]  r_iter;
   logic [3:0]  r_hund;
   logic [3:0]  r_tens;
   logic [3:0]  r_ones;
   logic [15:0] r_scan;
   logic [2:0]  r_digit;
   logic [7:0]  r_seg_com;
   logic [7:0]  r_seg_array;

   logic [11:0] w_bcd_adj;
   logic [19:0] w_shift;
   logic [7:0]  w_seg_next;

   function automatic logic [7:0] seg_encode(input logic [3:0] d);
      logic [7:0] s;
      case (d)
         4'd0:    s = 8'hFC;
         4'd1:    s = 8'h60;
         4'd2:    s = 8'hDA;
         4'd3:    s = 8'hF2;
         4'd4:    s = 8'h66;
         4'd5:    s = 8'hB6;
         4'd6:    s = 8'hBE;
         4'd7:    s = 8'hE4;
         4'd8:    s = 8'hFE;
         4'd9:    s = 8'hF6;
         default: s = 8'h00;
      endcase
      return s;
   endfunction

   always_comb begin
      w_bcd_adj[3:0]  = (r_bcd[3:0]  >= 4'd5) ? r_bcd[3:0]  + 4'd3 : r_bcd[3:0];
      w_bcd_adj[7:4]  = (r_bcd[7:4]  >= 4'd5) ? r_bcd[7:4]  + 4'd3 : r_bcd[7:4];
      w_bcd_adj[11:8] = (r_bcd[11:8] >= 4'd5) ? r_bcd[11:8] + 4'd3 : r_bcd[11:8];
      w_shift         = {w_bcd_adj, r_bin} << 1;
   end

   // Conversion FSM; display digits are written only in DONE.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
         r_valid <= 1'b0;
         r_last  <= 8'd0;
         r_bin   <= 8'd0;
         r_bcd   <= 12'd0;
         r_iter  <= 3'd0;
         r_hund  <= 4'd0;
         r_tens  <= 4'd0;
         r_ones  <= 4'd0;
      end else begin
         case (r_state)
            IDLE: begin
               if (!r_valid || (display_money_binary != r_last)) r_state <= LOAD;
            end
            LOAD: begin
               r_bin   <= display_money_binary;
               r_last  <= display_money_binary;
               r_bcd   <= 12'd0;
               r_iter  <= 3'd0;
               r_state <= SHIFT;
            end
            SHIFT: begin
               {r_bcd, r_bin} <= w_shift;
               r_iter         <= r_iter + 3'd1;
               if (r_iter == 3'd7) r_state <= DONE;
            end
            DONE: begin
               r_hund  <= r_bcd[11:8];
               r_tens  <= r_bcd[7:4];
               r_ones  <= r_bcd[3:0];
               r_valid <= 1'b1;
               r_state <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   always_comb begin
      w_seg_next = 8'h00;
      case (r_digit)
         3'd0: w_seg_next = seg_encode(r_ones);
         3'd1: w_seg_next = (r_hund == 4'd0 && r_tens == 4'd0) ? 8'h00 : seg_encode(r_tens);
         3'd2: w_seg_next = (r_hund == 4'd0) ? 8'h00 : seg_encode(r_hund);
         default: w_seg_next = 8'h00;
      endcase
   end

   // seg_com and seg_array are both derived from r_digit on the same edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_scan      <= 16'd0;
         r_digit     <= 3'd0;
         r_seg_com   <= 8'hFE;
         r_seg_array <= 8'hFC;
      end else begin
         if (r_scan == SCAN_MAX) begin
            r_scan  <= 16'd0;
            r_digit <= r_digit + 3'd1;
         end else begin
            r_scan <= r_scan + 16'd1;
         end
         r_seg_com   <= ~(8'b1 << r_digit);
         r_seg_array <= w_seg_next;
      end
   end

   assign seg_com   = r_seg_com;
   assign seg_array = r_seg_array;
   assign conv_busy = (r_state != IDLE);

endmodule

// File: tb/tb_money_bcd_scan.sv
// Directed bench for money_bcd_scan: conversion latency, scan walk, blanking,
// mid-conversion input change and asynchronous reset abort.
module tb_money_bcd_scan;

   logic       clk;
   logic       rst;
   logic [7:0] display_money_binary;
   logic [7:0] seg_com;
   logic [7:0] seg_array;
   logic       conv_busy;

   int n_checks;
   int n_errors;

   typedef struct {
      logic [7:0] val;
      logic [7:0] d0;
      logic [7:0] d1;
      logic [7:0] d2;
   } vec_t;

   vec_t vecs[13];
   logic [7:0] cap[8];

   money_bcd_scan #(.SCAN_DIV(4)) dut (
      .clk                  (clk),
      .rst                  (rst),
      .display_money_binary (display_money_binary),
      .seg_com              (seg_com),
      .seg_array            (seg_array),
      .conv_busy            (conv_busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic check_int(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Counts busy cycles of the next conversion; bounded so a stuck FSM cannot hang.
   task automatic conv_cycles(output int n);
      n = 0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (conv_busy) n++;
         else if (n > 0) break;
      end
   endtask

   task automatic capture(input logic [7:0] v, input logic [7:0] e0, input logic [7:0] e1,
                          input logic [7:0] e2);
      logic [7:0] exp;
      for (int j = 0; j < 8; j++) cap[j] = 8'hxx;
      @(negedge clk);
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         for (int j = 0; j < 8; j++) begin
            if (seg_com == ~(8'b1 << j)) cap[j] = seg_array;
         end
      end
      for (int j = 0; j < 8; j++) begin
         exp = (j == 0) ? e0 : (j == 1) ? e1 : (j == 2) ? e2 : 8'h00;
         check8($sformatf("disp%0d_digit%0d", v, j), cap[j], exp);
      end
   endtask

   initial begin
      int         n;
      int         nb;
      int         run;
      bit         first_run;
      logic [7:0] prev;

      n_checks = 0;
      n_errors = 0;

      vecs[0]  = '{8'd255, 8'hB6, 8'hB6, 8'hDA};
      vecs[1]  = '{8'd7,   8'hE4, 8'h00, 8'h00};
      vecs[2]  = '{8'd105, 8'hB6, 8'hFC, 8'h60};
      vecs[3]  = '{8'd10,  8'hFC, 8'h60, 8'h00};
      vecs[4]  = '{8'd100, 8'hFC, 8'hFC, 8'h60};
      vecs[5]  = '{8'd200, 8'hFC, 8'hFC, 8'hDA};
      vecs[6]  = '{8'd58,  8'hFE, 8'hB6, 8'h00};
      vecs[7]  = '{8'd123, 8'hF2, 8'hDA, 8'h60};
      vecs[8]  = '{8'd9,   8'hF6, 8'h00, 8'h00};
      vecs[9]  = '{8'd1,   8'h60, 8'h00, 8'h00};
      vecs[10] = '{8'd247, 8'hE4, 8'h66, 8'hDA};
      vecs[11] = '{8'd99,  8'hF6, 8'hF6, 8'h00};
      vecs[12] = '{8'd64,  8'h66, 8'hBE, 8'h00};

      rst = 1'b1;
      display_money_binary = 8'd0;
      repeat (3) @(negedge clk);
      check8("reset_seg_com", seg_com, 8'hFE);
      check8("reset_seg_array", seg_array, 8'hFC);
      check8("reset_busy", {7'd0, conv_busy}, 8'd0);
      rst = 1'b0;

      // Scan walk with input 0: rotating one-hot-low, 4 cycles per digit.
      prev = 8'hFE;
      run = 1;
      first_run = 1'b1;
      nb = 0;
      for (int i = 0; i < 72; i++) begin
         @(negedge clk);
         if (conv_busy) nb++;
         if (seg_com !== prev) begin
            if (!first_run) begin
               check_int("walk_hold", run, 4);
               check8("walk_next", seg_com, {prev[6:0], prev[7]});
            end
            first_run = 1'b0;
            run = 1;
            prev = seg_com;
         end else begin
            run++;
         end
         check8("walk_seg_array", seg_array, (seg_com == 8'hFE) ? 8'hFC : 8'h00);
      end
      check_int("post_reset_busy_cycles", nb, 10);

      for (int k = 0; k < 13; k++) begin
         display_money_binary = vecs[k].val;
         conv_cycles(n);
         check_int($sformatf("busy_cycles_%0d", vecs[k].val), n, 10);
         capture(vecs[k].val, vecs[k].d0, vecs[k].d1, vecs[k].d2);
      end

      // Input changes from 30 to 99 in the middle of SHIFT.
      display_money_binary = 8'd30;
      n = 0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (i == 5) display_money_binary = 8'd99;
         if (conv_busy) n++;
         else if (n > 0) break;
      end
      check_int("midchg_first_busy", n, 10);
      @(negedge clk);
      check8("midchg_rebusy", {7'd0, conv_busy}, 8'd1);
      n = 1;
      for (int i = 0; i < 50; i++) begin
         if (seg_com == 8'hFE) check8("midchg_shows30_ones", seg_array, 8'hFC);
         if (seg_com == 8'hFD) check8("midchg_shows30_tens", seg_array, 8'hF2);
         if (seg_com == 8'hFB) check8("midchg_shows30_hund", seg_array, 8'h00);
         if (!conv_busy) break;
         @(negedge clk);
         if (conv_busy) n++;
      end
      check_int("midchg_second_busy", n, 10);
      capture(8'd99, 8'hF6, 8'hF6, 8'h00);

      // Asynchronous reset during SHIFT while "150" is displayed.
      display_money_binary = 8'd150;
      conv_cycles(n);
      check_int("busy_cycles_150", n, 10);
      capture(8'd150, 8'hFC, 8'hB6, 8'h60);
      display_money_binary = 8'd42;
      repeat (5) @(negedge clk);
      check8("pre_abort_busy", {7'd0, conv_busy}, 8'd1);
      #2 rst = 1'b1;
      #1;
      check8("abort_seg_com", seg_com, 8'hFE);
      check8("abort_seg_array", seg_array, 8'hFC);
      check8("abort_busy", {7'd0, conv_busy}, 8'd0);
      repeat (2) @(negedge clk);
      check8("abort_hold_seg_com", seg_com, 8'hFE);
      check8("abort_hold_seg_array", seg_array, 8'hFC);
      rst = 1'b0;
      conv_cycles(n);
      check_int("post_abort_busy_cycles", n, 10);
      capture(8'd42, 8'hDA, 8'h66, 8'h00);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
